// File: rtl/guess_game_pkg.sv
// -----------------------------------------------------------------------------
// guess_game_pkg
// Shared constants for the number-guessing game controller: FSM state codes
// (as seen on state_out), hint codes, the default number of guesses per round
// and the guess grading helper.
// No ports (package).
// -----------------------------------------------------------------------------
package guess_game_pkg;

   // Default number of guesses allowed per round (legal range 1..15)
   localparam int unsigned MAX_TRIES_DEFAULT = 32'd7;

   // FSM state codes, identical to the encoding driven on state_out
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_PLAY = 2'b01;
   localparam logic [1:0] ST_WIN  = 2'b10;
   localparam logic [1:0] ST_LOSE = 2'b11;

   // Hint codes describing the most recent guess
   localparam logic [1:0] HINT_NONE    = 2'b00;
   localparam logic [1:0] HINT_LOW     = 2'b01;
   localparam logic [1:0] HINT_HIGH    = 2'b10;
   localparam logic [1:0] HINT_CORRECT = 2'b11;

   // Unsigned comparison of a guess against the secret value
   function automatic logic [1:0] grade_guess(input logic [3:0] guess,
                                              input logic [3:0] secret);
      logic [1:0] grade;
      if (guess == secret) begin
         grade = HINT_CORRECT;
      end else if (guess < secret) begin
         grade = HINT_LOW;
      end else begin
         grade = HINT_HIGH;
      end
      return grade;
   endfunction

endpackage

// File: rtl/btn_fall_edge.sv
// -----------------------------------------------------------------------------
// btn_fall_edge
// Release detector for an already synchronised, debounced button. A release
// event is flagged combinationally in the cycle where the registered previous
// level is 1 and the current level is 0, so the consumer can act on the same
// clock edge at which the release is seen.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset (clears the previous-level flop)
//   btn  - button level, synchronous to clk
//   fall - one-cycle release event
// -----------------------------------------------------------------------------
module btn_fall_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic fall
);

   logic prev_r;

   // Capture last cycle's button level; cleared on reset so a button that is
   // already low at release cannot look like a fresh release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_r <= 1'b0;
      end else begin
         prev_r <= btn;
      end
   end

   assign fall = prev_r & ~btn;

endmodule

// File: rtl/guess_game_ctrl.sv
// -----------------------------------------------------------------------------
// guess_game_ctrl
// Round controller for a 4-bit number-guessing game. A release of rng_button
// latches rng_value as the secret and starts a round; each release of
// guess_button during a round grades guess_value against the secret. The
// round ends in WIN on a correct guess or in LOSE once MAX_TRIES incorrect
// guesses have been used. All outputs are registered and change on the same
// edge at which a button release is detected.
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-low reset
//   rng_button   - start/restart button (release = event)
//   rng_value    - free-running random value, sampled on a start event
//   guess_button - guess-submit button (release = event)
//   guess_value  - player guess, sampled on a submit event
//   target       - latched secret value
//   tries        - guesses submitted this round
//   hint         - grade of last guess (none / low / high / correct)
//   state_out    - FSM state code
//   win, lose    - high while in WIN / LOSE
// -----------------------------------------------------------------------------
module guess_game_ctrl
   import guess_game_pkg::*;
#(
   parameter int unsigned MAX_TRIES = MAX_TRIES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rng_button,
   input  logic [3:0] rng_value,
   input  logic       guess_button,
   input  logic [3:0] guess_value,
   output logic [3:0] target,
   output logic [3:0] tries,
   output logic [1:0] hint,
   output logic [1:0] state_out,
   output logic       win,
   output logic       lose
);

   localparam logic [3:0] MAX_TRIES_C = 4'(MAX_TRIES);

   logic       rng_evt_s;
   logic       guess_evt_s;

   logic [1:0] state_r;
   logic [3:0] target_r;
   logic [3:0] tries_r;
   logic [1:0] hint_r;
   logic       win_r;
   logic       lose_r;

   logic [1:0] state_nx_s;
   logic [3:0] target_nx_s;
   logic [3:0] tries_nx_s;
   logic [1:0] hint_nx_s;
   logic [3:0] tries_inc_s;
   logic [1:0] grade_s;

   btn_fall_edge u_rng_edge (
      .clk  (clk),
      .rst  (rst),
      .btn  (rng_button),
      .fall (rng_evt_s)
   );

   btn_fall_edge u_guess_edge (
      .clk  (clk),
      .rst  (rst),
      .btn  (guess_button),
      .fall (guess_evt_s)
   );

   // Next-state and next-output computation for the round FSM
   always_comb begin
      state_nx_s  = state_r;
      target_nx_s = target_r;
      tries_nx_s  = tries_r;
      hint_nx_s   = hint_r;
      tries_inc_s = tries_r + 4'd1;
      grade_s     = grade_guess(guess_value, target_r);

      case (state_r)
         // Outside a round only a start event matters; guesses are dropped
         ST_IDLE, ST_WIN, ST_LOSE: begin
            if (rng_evt_s) begin
               state_nx_s  = ST_PLAY;
               target_nx_s = rng_value;
               tries_nx_s  = 4'd0;
               hint_nx_s   = HINT_NONE;
            end else begin
               state_nx_s  = state_r;
            end
         end
         // During a round the target is locked: rng events are ignored even
         // when they coincide with a guess
         ST_PLAY: begin
            if (guess_evt_s) begin
               tries_nx_s = tries_inc_s;
               hint_nx_s  = grade_s;
               if (grade_s == HINT_CORRECT) begin
                  state_nx_s = ST_WIN;
               end else if (tries_inc_s >= MAX_TRIES_C) begin
                  // >= keeps tries bounded even if the counter were corrupted
                  state_nx_s = ST_LOSE;
               end else begin
                  state_nx_s = ST_PLAY;
               end
            end else begin
               state_nx_s = ST_PLAY;
            end
         end
         default: begin
            state_nx_s  = ST_IDLE;
            target_nx_s = 4'd0;
            tries_nx_s  = 4'd0;
            hint_nx_s   = HINT_NONE;
         end
      endcase
   end

   // Output and state registers; win/lose decoded from the next state so they
   // change on the same edge as state_out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         target_r <= 4'd0;
         tries_r  <= 4'd0;
         hint_r   <= HINT_NONE;
         win_r    <= 1'b0;
         lose_r   <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         target_r <= target_nx_s;
         tries_r  <= tries_nx_s;
         hint_r   <= hint_nx_s;
         win_r    <= (state_nx_s == ST_WIN);
         lose_r   <= (state_nx_s == ST_LOSE);
      end
   end

   assign target    = target_r;
   assign tries     = tries_r;
   assign hint      = hint_r;
   assign state_out = state_r;
   assign win       = win_r;
   assign lose      = lose_r;

endmodule
